uart_axi4lite_stream_master: RTL and testbench



---
 rtl/uart_axi4lite_stream_master.sv | 214 +++++++++++++++++++++
 tb/tb_uart_axi4lite_stream_master.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axi4lite_stream_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_axi4lite_stream_master
// Purpose  : AXI4-Lite master moving tx/rx byte streams through the UART
//            register slave (TX_DATA/TX_BUSY/RX_DATA/RX_DRDY).
// Revision : 1.0  initial release
// ============================================================================
module uart_axi4lite_stream_master #(
    parameter int AXI_AWIDTH = 4,
    parameter int AXI_DWIDTH = 32,
    parameter int DATA_BITS  = 8,
    parameter int POLL_GAP   = 16,
    parameter int TX_SETTLE  = 4
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,
    output logic [AXI_AWIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]   M_AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    input  logic [DATA_BITS-1:0]    S_TDATA,
    input  logic                    S_TVALID,
    output logic                    S_TREADY,
    output logic [DATA_BITS-1:0]    M_TDATA,
    output logic                    M_TVALID,
    input  logic                    M_TREADY,
    output logic                    ERR
);

    localparam int STRB_W   = AXI_DWIDTH / 8;
    localparam int LANES    = (DATA_BITS + 7) / 8;
    localparam int SETTLE_W = $clog2(TX_SETTLE + 1);
    localparam int POLL_W   = $clog2(POLL_GAP + 1);

    localparam logic [AXI_AWIDTH-1:0] ADDR_TX_DATA = AXI_AWIDTH'(0);
    localparam logic [AXI_AWIDTH-1:0] ADDR_TX_BUSY = AXI_AWIDTH'(4);
    localparam logic [AXI_AWIDTH-1:0] ADDR_RX_DATA = AXI_AWIDTH'(8);
    localparam logic [AXI_AWIDTH-1:0] ADDR_RX_DRDY = AXI_AWIDTH'(12);
    localparam logic [STRB_W-1:0]     WSTRB_BYTE   = STRB_W'((64'd1 << LANES) - 64'd1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_POLL  = 3'd1,
        TX_WRITE = 3'd2,
        RX_POLL  = 3'd3,
        RX_READ  = 3'd4
    } state_t;

    state_t                state;
    logic                  prio_rx;
    logic                  out_of_reset;
    logic                  tx_full;
    logic [DATA_BITS-1:0]  tx_byte;
    logic                  rx_full;
    logic [DATA_BITS-1:0]  rx_byte;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [POLL_W-1:0]     poll_cnt;

    logic r_hs;
    logic b_hs;
    logic rd_err;
    logic wr_err;
    logic rx_eligible;
    logic tx_go;

    assign r_hs        = M_AXI_RVALID & M_AXI_RREADY;
    assign b_hs        = M_AXI_BVALID & M_AXI_BREADY;
    assign rd_err      = (M_AXI_RRESP != 2'b00);
    assign wr_err      = (M_AXI_BRESP != 2'b00);
    assign rx_eligible = (poll_cnt == '0) && !rx_full;
    assign tx_go       = tx_full && (settle_cnt == '0) && (!prio_rx || !rx_eligible);

    // S_TREADY stays low while reset is held and for the first cycle after it
    assign S_TREADY = out_of_reset & ~tx_full;
    assign M_TVALID = rx_full;
    assign M_TDATA  = rx_byte;

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state         <= IDLE;
            prio_rx       <= 1'b0;
            out_of_reset  <= 1'b0;
            tx_full       <= 1'b0;
            tx_byte       <= '0;
            rx_full       <= 1'b0;
            rx_byte       <= '0;
            settle_cnt    <= '0;
            poll_cnt      <= '0;
            ERR           <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;

            if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            if (poll_cnt != '0)   poll_cnt   <= poll_cnt - 1'b1;

            if (S_TVALID && S_TREADY) begin
                tx_full <= 1'b1;
                tx_byte <= S_TDATA;
            end
            if (M_TVALID && M_TREADY) rx_full <= 1'b0;

            // Each valid falls on its own handshake, independent of the others
            if (M_AXI_ARVALID && M_AXI_ARREADY) M_AXI_ARVALID <= 1'b0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;

            if (r_hs && rd_err) ERR <= 1'b1;
            if (b_hs && wr_err) ERR <= 1'b1;

            case (state)
                IDLE: begin
                    if (tx_go) begin
                        state         <= TX_POLL;
                        M_AXI_ARADDR  <= ADDR_TX_BUSY;
                        M_AXI_ARVALID <= 1'b1;
                        M_AXI_RREADY  <= 1'b1;
                    end else if (rx_eligible) begin
                        state         <= RX_POLL;
                        M_AXI_ARADDR  <= ADDR_RX_DRDY;
                        M_AXI_ARVALID <= 1'b1;
                        M_AXI_RREADY  <= 1'b1;
                    end
                end

                TX_POLL: begin
                    if (r_hs) begin
                        M_AXI_RREADY  <= 1'b0;
                        M_AXI_ARVALID <= 1'b0;
                        prio_rx       <= 1'b1;
                        if (!rd_err && !M_AXI_RDATA[0]) begin
                            state         <= TX_WRITE;
                            M_AXI_AWADDR  <= ADDR_TX_DATA;
                            M_AXI_WDATA   <= AXI_DWIDTH'(tx_byte);
                            M_AXI_WSTRB   <= WSTRB_BYTE;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            M_AXI_BREADY  <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            settle_cnt <= SETTLE_W'(TX_SETTLE);
                        end
                    end
                end

                TX_WRITE: begin
                    if (b_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b0;
                        M_AXI_BREADY  <= 1'b0;
                        settle_cnt    <= SETTLE_W'(TX_SETTLE);
                        state         <= IDLE;
                        // A rejected write keeps the byte so it is sent again
                        if (!wr_err) tx_full <= 1'b0;
                    end
                end

                RX_POLL: begin
                    if (r_hs) begin
                        M_AXI_RREADY  <= 1'b0;
                        M_AXI_ARVALID <= 1'b0;
                        prio_rx       <= 1'b0;
                        if (!rd_err && M_AXI_RDATA[0]) begin
                            state         <= RX_READ;
                            M_AXI_ARADDR  <= ADDR_RX_DATA;
                            M_AXI_ARVALID <= 1'b1;
                            M_AXI_RREADY  <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            poll_cnt <= POLL_W'(POLL_GAP);
                        end
                    end
                end

                RX_READ: begin
                    if (r_hs) begin
                        M_AXI_RREADY  <= 1'b0;
                        M_AXI_ARVALID <= 1'b0;
                        state         <= IDLE;
                        if (!rd_err) begin
                            rx_byte <= M_AXI_RDATA[DATA_BITS-1:0];
                            rx_full <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_axi4lite_stream_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_axi4lite_stream_master
// Purpose  : Self-checking bench with a reactive UART register slave model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_axi4lite_stream_master;
    localparam int POLL_GAP  = 16;
    localparam int TX_SETTLE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;
    logic [7:0]  s_tdata = 0;
    logic        s_tvalid = 0, m_tready = 1;
    logic        s_tready, m_tvalid, err;
    logic [7:0]  m_tdata;

    uart_axi4lite_stream_master #(
        .AXI_AWIDTH(4), .AXI_DWIDTH(32), .DATA_BITS(8),
        .POLL_GAP(POLL_GAP), .TX_SETTLE(TX_SETTLE)
    ) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .S_TDATA(s_tdata), .S_TVALID(s_tvalid), .S_TREADY(s_tready),
        .M_TDATA(m_tdata), .M_TVALID(m_tvalid), .M_TREADY(m_tready),
        .ERR(err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // slave configuration and transaction log
    int ar_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int busy_polls = 0, err_writes = 0;
    bit busy_rand = 0;
    bit last_busy = 0;
    bit mon_en = 0;
    logic [7:0]  rx_src[$];
    logic [7:0]  rx_got[$];
    logic [3:0]  rd_addr_log[$];
    logic [31:0] rd_data_log[$];
    int          rd_cyc_log[$];
    logic [3:0]  wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [3:0]  wr_strb_log[$];
    logic [1:0]  wr_resp_log[$];
    bit          wr_busy_log[$];

    logic ar_hs_q = 0, r_hs_q = 0, aw_hs_q = 0, w_hs_q = 0, b_hs_q = 0, s_hs_q = 0;
    logic [3:0]  ar_addr_q = 0, aw_addr_q = 0;
    logic [31:0] w_data_q = 0;
    logic [3:0]  w_strb_q = 0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        ar_hs_q   <= arvalid && arready;
        ar_addr_q <= araddr;
        r_hs_q    <= rvalid && rready;
        aw_hs_q   <= awvalid && awready;
        aw_addr_q <= awaddr;
        w_hs_q    <= wvalid && wready;
        w_data_q  <= wdata;
        w_strb_q  <= wstrb;
        b_hs_q    <= bvalid && bready;
        s_hs_q    <= s_tvalid && s_tready;
        if (m_tvalid && m_tready) rx_got.push_back(m_tdata);
    end

    task automatic slave_read(input logic [3:0] a, output logic [31:0] d);
        d = 32'd0;
        case (a)
            4'h4: begin
                if (busy_rand) d = ($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0;
                else if (busy_polls > 0) begin d = 32'd1; busy_polls--; end
                last_busy = d[0];
            end
            4'hC: d = (rx_src.size() > 0) ? 32'd1 : 32'd0;
            4'h8: if (rx_src.size() > 0) d = {24'd0, rx_src.pop_front()};
            default: d = 32'd0;
        endcase
        rd_addr_log.push_back(a);
        rd_data_log.push_back(d);
        rd_cyc_log.push_back(cyc);
    endtask

    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit got_aw = 0, got_w = 0;
    logic [3:0]  sl_waddr = 0;
    logic [31:0] sl_wdata = 0;
    logic [3:0]  sl_wstrb = 0;

    // slave model reacts on the falling edge so DUT sampling never races it
    always @(negedge clk) begin
        if (!rst_n) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; got_aw = 0; got_w = 0;
        end else begin
            logic [31:0] d;
            if (r_hs_q) rvalid = 0;
            if (ar_hs_q) begin
                slave_read(ar_addr_q, d);
                rdata = d; rresp = 2'b00; rvalid = 1;
            end
            if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (b_hs_q) begin bvalid = 0; got_aw = 0; got_w = 0; b_cnt = 0; end
            if (aw_hs_q) begin got_aw = 1; sl_waddr = aw_addr_q; end
            if (w_hs_q)  begin got_w = 1; sl_wdata = w_data_q; sl_wstrb = w_strb_q; end
            if (got_aw && got_w && !bvalid && !b_hs_q) begin
                if (b_cnt >= b_delay) begin
                    bvalid = 1;
                    bresp  = (err_writes > 0) ? 2'b10 : 2'b00;
                    if (err_writes > 0) err_writes--;
                    wr_addr_log.push_back(sl_waddr);
                    wr_data_log.push_back(sl_wdata);
                    wr_strb_log.push_back(sl_wstrb);
                    wr_resp_log.push_back(bresp);
                    wr_busy_log.push_back(last_busy);
                end else b_cnt++;
            end
        end
    end

    // channel rules: valids and payloads held until their own handshake
    logic p_arvalid = 0, p_arready = 0, p_awvalid = 0, p_awready = 0;
    logic p_wvalid = 0, p_wready = 0, p_rready = 0, p_rvalid = 0;
    logic [3:0]  p_araddr = 0, p_awaddr = 0;
    logic [31:0] p_wdata = 0;
    always @(posedge clk) begin
        if (mon_en && rst_n) begin
            n_checks++;
            if ((p_arvalid && !p_arready && (!arvalid || araddr !== p_araddr)) ||
                (p_arvalid && p_arready && arvalid)) begin
                n_fail++; $display("FAIL ar_hold: arvalid=%0b araddr=%h required held=%0b addr=%h", arvalid, araddr, !p_arready, p_araddr);
            end
            n_checks++;
            if ((p_awvalid && !p_awready && (!awvalid || awaddr !== p_awaddr)) ||
                (p_awvalid && p_awready && awvalid)) begin
                n_fail++; $display("FAIL aw_hold: awvalid=%0b awaddr=%h required held=%0b addr=%h", awvalid, awaddr, !p_awready, p_awaddr);
            end
            n_checks++;
            if ((p_wvalid && !p_wready && (!wvalid || wdata !== p_wdata)) ||
                (p_wvalid && p_wready && wvalid)) begin
                n_fail++; $display("FAIL w_hold: wvalid=%0b wdata=%h required held=%0b data=%h", wvalid, wdata, !p_wready, p_wdata);
            end
            n_checks++;
            if ((p_rready && !p_rvalid && !rready) || (arvalid && !p_arvalid && !rready)) begin
                n_fail++; $display("FAIL rready_hold: rready=%0b required 1", rready);
            end
        end
        p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
        p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
        p_wvalid = wvalid; p_wready = wready; p_wdata = wdata;
        p_rready = rready; p_rvalid = rvalid;
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 0;
        @(negedge clk);
        s_tvalid = 1; s_tdata = b;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (s_hs_q) begin ok = 1; break; end
        end
        s_tvalid = 0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL send_timeout: byte %h not accepted, required accepted", b); end
    endtask

    task automatic wait_writes(input int target);
        int i;
        for (i = 0; i < 3000 && wr_data_log.size() < target; i++) @(negedge clk);
        n_checks++;
        if (wr_data_log.size() < target) begin
            n_fail++; $display("FAIL write_timeout: writes=%0d required %0d", wr_data_log.size(), target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({arvalid, awvalid, wvalid, bready, rready, s_tready, m_tvalid, err} !== 8'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 00000000",
                {arvalid, awvalid, wvalid, bready, rready, s_tready, m_tvalid, err});
        end
        n_checks++;
        if (araddr !== 4'd0 || awaddr !== 4'd0 || wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: araddr=%h awaddr=%h wdata=%h required 0", araddr, awaddr, wdata);
        end
        rst_n = 1;
        @(negedge clk);
        n_checks++;
        if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_sready: got %b required 1", s_tready); end
        mon_en = 1;
    endtask

    task automatic test_tx_basic();
        int r0 = rd_addr_log.size(), w0 = wr_data_log.size();
        int n4 = 0, cyc4 = 0;
        bit ok, low_bad = 0;
        send_byte(8'h55, ok);
        for (int i = 0; i < 200 && !b_hs_q; i++) begin
            if (s_tready !== 1'b0) low_bad = 1;
            @(negedge clk);
        end
        n_checks++;
        if (low_bad) begin n_fail++; $display("FAIL tx_sready_low: went high before B, required low"); end
        n_checks++;
        if (s_tready !== 1'b1) begin n_fail++; $display("FAIL tx_sready_rise: got %b required 1 after B", s_tready); end
        wait_writes(w0 + 1);
        for (int i = r0; i < rd_addr_log.size(); i++)
            if (rd_addr_log[i] == 4'h4) begin n4++; cyc4 = rd_cyc_log[i]; end
        n_checks++;
        if (n4 != 1) begin n_fail++; $display("FAIL tx_poll_count: got %0d required 1", n4); end
        n_checks++;
        if (wr_data_log.size() > w0 && (wr_addr_log[w0] !== 4'h0 || wr_data_log[w0] !== 32'h55 || wr_strb_log[w0] !== 4'b0001)) begin
            n_fail++; $display("FAIL tx_write: addr=%h data=%h strb=%b required 0/00000055/0001",
                wr_addr_log[w0], wr_data_log[w0], wr_strb_log[w0]);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (wr_data_log.size() != w0 + 1) begin n_fail++; $display("FAIL tx_single: writes=%0d required %0d", wr_data_log.size(), w0 + 1); end
    endtask

    task automatic test_tx_busy();
        int r0 = rd_addr_log.size(), w0 = wr_data_log.size();
        int idx[$];
        bit ok, gap_bad = 0, val_bad = 0;
        busy_polls = 3;
        send_byte(8'hC7, ok);
        wait_writes(w0 + 1);
        for (int i = r0; i < rd_addr_log.size(); i++) if (rd_addr_log[i] == 4'h4) idx.push_back(i);
        n_checks++;
        if (idx.size() != 4) begin n_fail++; $display("FAIL busy_polls: got %0d polls required 4", idx.size()); end
        for (int k = 0; k < idx.size(); k++) begin
            if (rd_data_log[idx[k]] !== ((k < 3) ? 32'd1 : 32'd0)) val_bad = 1;
            if (k > 0 && rd_cyc_log[idx[k]] - rd_cyc_log[idx[k-1]] < TX_SETTLE) gap_bad = 1;
        end
        n_checks++;
        if (gap_bad) begin n_fail++; $display("FAIL busy_spacing: polls closer than %0d cycles", TX_SETTLE); end
        n_checks++;
        if (val_bad || wr_busy_log[w0]) begin n_fail++; $display("FAIL busy_write: write issued while busy, required only after busy=0"); end
        n_checks++;
        if (wr_data_log[w0] !== 32'hC7) begin n_fail++; $display("FAIL busy_data: got %h required 000000c7", wr_data_log[w0]); end
    endtask

    task automatic test_rx_hold();
        int n0, i, j8 = -1, got0;
        bit stable_bad = 0;
        m_tready = 0;
        rx_src.push_back(8'hA3);
        for (i = 0; i < 300 && !m_tvalid; i++) @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'hA3) begin
            n_fail++; $display("FAIL rx_present: tvalid=%b tdata=%h required 1/a3", m_tvalid, m_tdata);
        end
        n0 = rd_addr_log.size();
        for (i = 0; i < 3 * POLL_GAP; i++) begin
            @(negedge clk);
            if (m_tvalid !== 1'b1 || m_tdata !== 8'hA3) stable_bad = 1;
        end
        n_checks++;
        if (stable_bad) begin n_fail++; $display("FAIL rx_stable: output changed while held, required a3 held"); end
        n_checks++;
        if (rd_addr_log.size() != n0) begin n_fail++; $display("FAIL rx_no_poll: %0d extra reads required 0", rd_addr_log.size() - n0); end
        for (i = 1; i < n0; i++) if (rd_addr_log[i] == 4'h8) j8 = i;
        n_checks++;
        if (j8 < 1 || rd_addr_log[j8-1] !== 4'hC || rd_data_log[j8-1] !== 32'd1 || rd_data_log[j8] !== 32'hA3) begin
            n_fail++; $display("FAIL rx_sequence: data read index %0d not preceded by DRDY=1, required C then 8", j8);
        end
        got0 = rx_got.size();
        m_tready = 1;
        @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b0 || rx_got.size() != got0 + 1) begin
            n_fail++; $display("FAIL rx_handshake: tvalid=%b taken=%0d required 0/1", m_tvalid, rx_got.size() - got0);
        end
    endtask

    task automatic test_wait_states();
        int w0 = wr_data_log.size();
        bit ok;
        ar_delay = 3; aw_delay = 2; w_delay = 0; b_delay = 2;
        send_byte(8'h81, ok);
        wait_writes(w0 + 1);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_data_log[w0] !== 32'h81 || wr_strb_log[w0] !== 4'b0001) begin
            n_fail++; $display("FAIL ws_write: data=%h strb=%b required 00000081/0001", wr_data_log[w0], wr_strb_log[w0]);
        end
        ar_delay = 0; aw_delay = 0; b_delay = 0;
    endtask

    task automatic test_error();
        int w0 = wr_data_log.size();
        bit ok;
        err_writes = 1;
        send_byte(8'h3C, ok);
        wait_writes(w0 + 2);
        repeat (40) @(negedge clk);
        n_checks++;
        if (wr_data_log.size() != w0 + 2 || wr_data_log[w0] !== 32'h3C || wr_data_log[w0+1] !== 32'h3C) begin
            n_fail++; $display("FAIL err_retry: writes=%0d required 2 of 0000003c", wr_data_log.size() - w0);
        end
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b required 1", err); end
    endtask

    task automatic test_reset_mid_read();
        int i, w0, r0;
        bit ok, c_seen = 0;
        busy_polls = 1000;
        send_byte(8'h99, ok);
        ar_delay = 1000;
        for (i = 0; i < 200 && !arvalid; i++) @(negedge clk);
        mon_en = 0;
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: arvalid=%b rready=%b err=%b required 0/0/0", arvalid, rready, err);
        end
        @(negedge clk);
        busy_polls = 0; ar_delay = 0;
        w0 = wr_data_log.size(); r0 = rd_addr_log.size();
        @(negedge clk);
        rst_n = 1;
        repeat (100) @(negedge clk);
        for (i = r0; i < rd_addr_log.size(); i++) if (rd_addr_log[i] == 4'hC) c_seen = 1;
        n_checks++;
        if (!c_seen) begin n_fail++; $display("FAIL rst_restart: no DRDY poll seen, required poll after reset"); end
        n_checks++;
        if (wr_data_log.size() != w0 || s_tready !== 1'b1) begin
            n_fail++; $display("FAIL rst_drop: writes=%0d tready=%b required 0/1", wr_data_log.size() - w0, s_tready);
        end
        mon_en = 1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] tx_exp[$];
        logic [7:0] rx_exp[$];
        int w0 = wr_data_log.size(), g0 = rx_got.size();
        bit busy_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tx_exp.push_back(8'($urandom));
            rx_exp.push_back(8'($urandom));
        end
        foreach (rx_exp[i]) rx_src.push_back(rx_exp[i]);
        busy_rand = 1;
        fork
            begin
                bit ok;
                foreach (tx_exp[i]) begin
                    send_byte(tx_exp[i], ok);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                wait_writes(w0 + 20);
            end
            begin
                for (int i = 0; i < 6000 && rx_got.size() < g0 + 20; i++) begin
                    @(negedge clk);
                    m_tready = $urandom_range(0, 1);
                end
                m_tready = 1;
            end
        join
        busy_rand = 0;
        n_checks++;
        if (rx_got.size() != g0 + 20) begin n_fail++; $display("FAIL b2b_rx_count: got %0d required 20", rx_got.size() - g0); end
        for (int i = 0; i < 20 && g0 + i < rx_got.size(); i++) begin
            n_checks++;
            if (rx_got[g0+i] !== rx_exp[i]) begin n_fail++; $display("FAIL b2b_rx[%0d]: got %h required %h", i, rx_got[g0+i], rx_exp[i]); end
        end
        for (int i = 0; i < 20 && w0 + i < wr_data_log.size(); i++) begin
            n_checks++;
            if (wr_data_log[w0+i] !== {24'd0, tx_exp[i]} || wr_addr_log[w0+i] !== 4'h0) begin
                n_fail++; $display("FAIL b2b_tx[%0d]: got %h required %h", i, wr_data_log[w0+i], tx_exp[i]);
            end
            if (wr_busy_log[w0+i]) busy_bad = 1;
        end
        n_checks++;
        if (busy_bad) begin n_fail++; $display("FAIL b2b_busy: write issued while TX_BUSY=1, required none"); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_busy();
        test_rx_hold();
        test_wait_states();
        test_back_to_back();
        test_error();
        test_reset_mid_read();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
